sand_flow_ctrl: RTL and testbench
=================================

SAND_FLOW_CTRL -- requirements
Module: sand_flow_ctrl

Interface
REQ-001 Parameter GRAINS, default 60, total grain count, range 1..255.
REQ-002 Parameter DROP_FRAMES, default 4, frames between grain releases, range 1..255.
REQ-003 Parameter FALL_LEN, default 10, rows a grain travels through the neck; matches the neck brick height.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 BTN_S  in  1  reset, synchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 flip_btn  in  1  debounced flip button, level.
REQ-008 neck_col  in  11  neck centre column.
REQ-009 neck_row  in  11  neck top row.
REQ-010 top_count  out  8  grains in the upper bulb.
REQ-011 bot_count  out  8  grains in the lower bulb.
REQ-012 grain_col  out  11  column of the in-flight grain.
REQ-013 grain_row  out  11  row of the in-flight grain.
REQ-014 grain_vis  out  1  high while a grain is in flight.
REQ-015 state  out  2  FSM state: IDLE=0, WAIT=1, FALL=2, EMPTY=3.
REQ-016 done  out  1  high while in EMPTY.

Function
REQ-017 The block SHALL detect rising edges of flip_btn with one registered sample; flip_rise is high for one cycle per press.
REQ-018 IDLE SHALL hold all counts; on flip_rise it SHALL go to WAIT and clear the frame counter.
REQ-019 In WAIT, each frame_tick SHALL increment the frame counter.
REQ-020 In WAIT, on the frame_tick where the frame counter equals DROP_FRAMES-1, the block SHALL act on the next edge as follows:
- top_count>0: decrement top_count, load grain_row=neck_row and grain_col=neck_col, set grain_vis=1, go to FALL.
- top_count==0: go to EMPTY.
REQ-021 In FALL, each frame_tick SHALL increment grain_row by 1. When grain_row-neck_row equals FALL_LEN-1 on that tick, the block SHALL instead clear grain_vis, increment bot_count, clear the frame counter and go to WAIT.
REQ-022 A flip_rise in WAIT SHALL swap top_count and bot_count, clear the frame counter and stay in WAIT.
REQ-023 A flip_rise in FALL SHALL set a pending flag; the grain still lands. At landing the block SHALL swap the counts, with the landed grain included in the swap, clear the flag and go to WAIT.
REQ-024 A flip_rise in EMPTY SHALL swap the counts and go to WAIT.
REQ-025 If flip_rise and a releasing frame_tick coincide in WAIT, the flip SHALL take priority and no grain is released that cycle.
REQ-026 top_count+bot_count+grain_vis SHALL equal GRAINS at all times outside reset.
REQ-027 Counts SHALL never wrap: top_count is not decremented at 0, and bot_count never exceeds GRAINS.
REQ-028 done SHALL be registered and equal (state==EMPTY).

Reset
REQ-029 On BTN_S high at a clk edge, the block SHALL set top_count=GRAINS, bot_count=0, grain_row=0, grain_col=0, grain_vis=0, state=IDLE, done=0, frame counter=0 and pending flag=0, from any state.
REQ-030 Reset SHALL abort a grain in flight; that grain is discarded and not counted.
REQ-031 The flip edge detector SHALL reset its sample to 0, so a button held through reset produces a flip_rise on the first post-reset cycle.

Configuration
REQ-032 With macro SAND_PAUSE_EN defined, the block SHALL add input pause_btn (1 bit). While pause_btn is high, frame_tick SHALL be ignored, freezing counts, grain_row and the frame counter; flip_rise SHALL still be honoured.
REQ-033 Without SAND_PAUSE_EN, the pause_btn port SHALL not exist and every frame_tick SHALL be accepted.

Verification
REQ-034 Reset, then flip_rise, then 4 ticks -> top_count=59, grain_vis=1, grain_row=neck_row, state=2.
REQ-035 10 further ticks after a release -> grain_row reaches neck_row+9, then grain_vis=0, bot_count=1, state=1.
REQ-036 GRAINS=3, run to completion -> top=0, bot=3, state=3, done=1; flip_rise -> top=3, bot=0, state=1.
REQ-037 flip_rise mid-FALL with top=58 and bot=1 -> at landing top=2 and bot=58, grain_vis=0, state=1.
REQ-038 flip_rise coincident with the releasing tick in WAIT -> counts swapped, grain_vis stays 0.
REQ-039 BTN_S asserted in FALL -> next edge top=GRAINS, bot=0, grain_vis=0, state=0.

Source files
------------

// File: rtl/sand_flow_ctrl.sv
// rtl/sand_flow_ctrl.sv - hourglass grain flow controller (optional pause input under SAND_PAUSE_EN)
module sand_flow_ctrl #(
    parameter int GRAINS      = 60,
    parameter int DROP_FRAMES = 4,
    parameter int FALL_LEN    = 10
) (
    input  logic        clk,
    input  logic        BTN_S,
    input  logic        frame_tick,
    input  logic        flip_btn,
`ifdef SAND_PAUSE_EN
    input  logic        pause_btn,
`endif
    input  logic [10:0] neck_col,
    input  logic [10:0] neck_row,
    output logic [7:0]  top_count,
    output logic [7:0]  bot_count,
    output logic [10:0] grain_col,
    output logic [10:0] grain_row,
    output logic        grain_vis,
    output logic [1:0]  state,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FALL  = 2'd2,
        S_EMPTY = 2'd3
    } state_t;

    localparam logic [7:0]  GRAINS_W  = 8'(GRAINS);
    localparam logic [7:0]  DROP_LAST = 8'(DROP_FRAMES - 1);
    localparam logic [10:0] FALL_LAST = 11'(FALL_LEN - 1);

    state_t      st;
    logic        flip_q;
    logic        flip_rise;
    logic        tick;
    logic        pend;
    logic [7:0]  frame_cnt;
    logic [10:0] fall_dist;
    logic        landing;
    logic        swap_now;
    logic [7:0]  bot_landed;

    assign state     = st;
    assign flip_rise = flip_btn & ~flip_q;

`ifdef SAND_PAUSE_EN
    assign tick = frame_tick & ~pause_btn;
`else
    assign tick = frame_tick;
`endif

    assign fall_dist  = grain_row - neck_row;
    assign landing    = tick && (fall_dist == FALL_LAST);
    // A flip on the landing tick itself counts the same as one latched earlier in the fall.
    assign swap_now   = pend | flip_rise;
    assign bot_landed = (bot_count < GRAINS_W) ? bot_count + 8'd1 : bot_count;

    always_ff @(posedge clk) begin
        if (BTN_S) begin
            st        <= S_IDLE;
            flip_q    <= 1'b0;
            pend      <= 1'b0;
            frame_cnt <= 8'd0;
            top_count <= GRAINS_W;
            bot_count <= 8'd0;
            grain_row <= 11'd0;
            grain_col <= 11'd0;
            grain_vis <= 1'b0;
            done      <= 1'b0;
        end else begin
            flip_q <= flip_btn;
            case (st)
                S_IDLE: begin
                    if (flip_rise) begin
                        st        <= S_WAIT;
                        frame_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (flip_rise) begin
                        top_count <= bot_count;
                        bot_count <= top_count;
                        frame_cnt <= 8'd0;
                    end else if (tick) begin
                        if (frame_cnt == DROP_LAST) begin
                            frame_cnt <= 8'd0;
                            if (top_count != 8'd0) begin
                                top_count <= top_count - 8'd1;
                                grain_row <= neck_row;
                                grain_col <= neck_col;
                                grain_vis <= 1'b1;
                                st        <= S_FALL;
                            end else begin
                                st   <= S_EMPTY;
                                done <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                S_FALL: begin
                    if (landing) begin
                        grain_vis <= 1'b0;
                        frame_cnt <= 8'd0;
                        pend      <= 1'b0;
                        st        <= S_WAIT;
                        if (swap_now) begin
                            top_count <= bot_landed;
                            bot_count <= top_count;
                        end else begin
                            bot_count <= bot_landed;
                        end
                    end else begin
                        if (flip_rise) pend <= 1'b1;
                        if (tick) grain_row <= grain_row + 11'd1;
                    end
                end
                S_EMPTY: begin
                    if (flip_rise) begin
                        top_count <= bot_count;
                        bot_count <= top_count;
                        frame_cnt <= 8'd0;
                        done      <= 1'b0;
                        st        <= S_WAIT;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sand_flow_ctrl.sv
// tb/tb_sand_flow_ctrl.sv - scoreboard bench for sand_flow_ctrl with a behavioural hourglass model
module tb_sand_flow_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tick, btn;
    logic [10:0] ncol, nrow;

    logic [7:0]  t0, b0, t1, b1;
    logic [10:0] gc0, gr0, gc1, gr1;
    logic        gv0, gv1, dn0, dn1;
    logic [1:0]  st0, st1;

    sand_flow_ctrl u0 (
        .clk(clk), .BTN_S(rst), .frame_tick(tick), .flip_btn(btn),
        .neck_col(ncol), .neck_row(nrow),
        .top_count(t0), .bot_count(b0), .grain_col(gc0), .grain_row(gr0),
        .grain_vis(gv0), .state(st0), .done(dn0)
    );

    sand_flow_ctrl #(.GRAINS(3), .DROP_FRAMES(2), .FALL_LEN(3)) u1 (
        .clk(clk), .BTN_S(rst), .frame_tick(tick), .flip_btn(btn),
        .neck_col(ncol), .neck_row(nrow),
        .top_count(t1), .bot_count(b1), .grain_col(gc1), .grain_row(gr1),
        .grain_vis(gv1), .state(st1), .done(dn1)
    );

    // mode: 0 idle, 1 waiting for a release, 2 grain falling, 3 upper bulb exhausted
    typedef struct {
        int top; int bot; int vis; int pos; int frames; int mode; int pend; int prev;
    } mdl_t;

    typedef struct {
        int top; int bot; int vis; int row; int col; int st; int done;
    } exp_t;

    mdl_t m0, m1;
    exp_t q0[$], q1[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic mdl_t mstep(input mdl_t m, input bit r, input bit tk, input bit b,
                                   input int g, input int d, input int l);
        mdl_t n;
        bit   rise;
        int   t;
        n = m;
        if (r) begin
            n.top = g; n.bot = 0; n.vis = 0; n.pos = 0;
            n.frames = 0; n.mode = 0; n.pend = 0; n.prev = 0;
            return n;
        end
        rise   = b && (m.prev == 0);
        n.prev = b;
        case (m.mode)
            0: if (rise) begin n.mode = 1; n.frames = 0; end
            1: begin
                if (rise) begin
                    t = n.top; n.top = n.bot; n.bot = t; n.frames = 0;
                end else if (tk) begin
                    n.frames++;
                    if (n.frames == d) begin
                        n.frames = 0;
                        if (n.top > 0) begin
                            n.top--; n.vis = 1; n.pos = 0; n.mode = 2;
                        end else begin
                            n.mode = 3;
                        end
                    end
                end
            end
            2: begin
                if (rise) n.pend = 1;
                if (tk) begin
                    if (n.pos == l - 1) begin
                        n.vis = 0; n.bot++;
                        if (n.pend != 0) begin t = n.top; n.top = n.bot; n.bot = t; end
                        n.pend = 0; n.mode = 1; n.frames = 0;
                    end else begin
                        n.pos++;
                    end
                end
            end
            default: if (rise) begin
                t = n.top; n.top = n.bot; n.bot = t; n.mode = 1; n.frames = 0;
            end
        endcase
        return n;
    endfunction

    function automatic exp_t mexp(input mdl_t m);
        exp_t e;
        e.top = m.top; e.bot = m.bot; e.vis = m.vis;
        e.row = int'(nrow) + m.pos; e.col = int'(ncol);
        e.st = m.mode; e.done = (m.mode == 3) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic cmp(input string nm, input exp_t e, input int tp, input int bt, input int vs,
                       input int rw, input int cl, input int sv, input int dn, input int g);
        bit ok;
        ok = (tp == e.top) && (bt == e.bot) && (vs == e.vis) && (sv == e.st) && (dn == e.done);
        if (e.vis != 0) ok = ok && (rw == e.row) && (cl == e.col);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s @%0t: got top=%0d bot=%0d vis=%0d row=%0d col=%0d st=%0d done=%0d expected top=%0d bot=%0d vis=%0d row=%0d col=%0d st=%0d done=%0d",
                      nm, $time, tp, bt, vs, rw, cl, sv, dn,
                      e.top, e.bot, e.vis, e.row, e.col, e.st, e.done);
        check({nm, "_sum"}, tp + bt + vs, g);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp("dut60", e, t0, b0, gv0, gr0, gc0, st0, dn0, 60);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("dut3", e, t1, b1, gv1, gr1, gc1, st1, dn1, 3);
            end
        end
    end

    task automatic step(input bit r, input bit tk, input bit b);
        @(negedge clk);
        #1;
        rst = r; tick = tk; btn = b;
        m0 = mstep(m0, r, tk, b, 60, 4, 10);
        m1 = mstep(m1, r, tk, b, 3, 2, 3);
        q0.push_back(mexp(m0));
        q1.push_back(mexp(m1));
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic press();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit lvl;
        rst = 1'b1; tick = 1'b0; btn = 1'b0;
        ncol = 11'($urandom_range(0, 1500));
        nrow = 11'($urandom_range(0, 1500));
        m0 = mstep(m0, 1'b1, 1'b0, 1'b0, 60, 4, 10);
        m1 = mstep(m1, 1'b1, 1'b0, 1'b0, 3, 2, 3);

        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        settle();
        check("rst_top", t0, 60);   check("rst_bot", b0, 0);
        check("rst_row", gr0, 0);   check("rst_col", gc0, 0);
        check("rst_vis", gv0, 0);   check("rst_state", st0, 0);
        check("rst_done", dn0, 0);

        press();
        ticks(4);
        settle();
        check("rel_top", t0, 59);   check("rel_vis", gv0, 1);
        check("rel_row", gr0, int'(nrow)); check("rel_col", gc0, int'(ncol));
        check("rel_state", st0, 2);

        ticks(9);
        settle();
        check("fall_row", gr0, int'(nrow) + 9); check("fall_vis", gv0, 1);
        ticks(1);
        settle();
        check("land_vis", gv0, 0);  check("land_bot", b0, 1); check("land_state", st0, 1);

        ticks(4);
        ticks(2);
        press();
        ticks(7);
        settle();
        check("pend_vis", gv0, 1);
        ticks(1);
        settle();
        check("pend_top", t0, 2);   check("pend_bot", b0, 58);
        check("pend_vis0", gv0, 0); check("pend_state", st0, 1);

        ticks(3);
        step(1'b0, 1'b1, 1'b1);
        settle();
        check("coin_top", t0, 58);  check("coin_bot", b0, 2);
        check("coin_vis", gv0, 0);  check("coin_state", st0, 1);
        step(1'b0, 1'b0, 1'b0);

        ticks(4);
        settle();
        check("pre_rst_state", st0, 2);
        step(1'b1, 1'b0, 1'b0);
        settle();
        check("abort_top", t0, 60); check("abort_bot", b0, 0);
        check("abort_vis", gv0, 0); check("abort_state", st0, 0);

        press();
        ticks(40);
        settle();
        check("empty_top", t1, 0);  check("empty_bot", b1, 3);
        check("empty_state", st1, 3); check("empty_done", dn1, 1);
        step(1'b0, 1'b0, 1'b1);
        settle();
        check("refill_top", t1, 3); check("refill_bot", b1, 0);
        check("refill_state", st1, 1); check("refill_done", dn1, 0);
        step(1'b0, 1'b0, 1'b0);

        lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) lvl = ~lvl;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), lvl);
        end
        step(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
